// File: rtl/univ_shift_reg.sv
// Universal shift register: manual hold/shift/load modes plus an automatic
// LSB-first serialise burst driven by a two-state controller.

module usr_cell (
  input  logic [1:0] op,
  input  logic       cur,
  input  logic       hi,
  input  logic       lo,
  input  logic       ld,
  output logic       nxt
);
  // op shares the mode encoding: hold, shift right, shift left, load
  always_comb begin
    nxt = cur;
    case (op)
      2'b01:   nxt = hi;
      2'b10:   nxt = lo;
      2'b11:   nxt = ld;
      default: nxt = cur;
    endcase
  end
endmodule

module univ_shift_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic                         sin_r,
  input  logic                         sin_l,
  input  logic [WIDTH-1:0]             pdin,
  input  logic                         start,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   cnt
);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SR   = 2'b01;
  localparam logic [1:0] OP_LD   = 2'b11;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              done_nxt;
  logic [1:0]        op;
  logic [WIDTH-1:0]  q_nxt, from_hi, from_lo;

  assign from_hi = {sin_r, q[WIDTH-1:1]};
  assign from_lo = {q[WIDTH-2:0], sin_l};
  assign sout_r  = q[0];
  assign sout_l  = q[WIDTH-1];
  assign busy    = (state == SHIFT);

  // Controller picks the datapath op; start wins over mode, and in SHIFT
  // both are ignored. en=0 forces hold and drops any pending done.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    op        = OP_HOLD;
    if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            op        = OP_LD;
            cnt_nxt   = CW'(WIDTH);
            state_nxt = SHIFT;
          end else begin
            op = mode;
          end
        end
        SHIFT: begin
          op      = OP_SR;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell u_cell (
      .op  (op),
      .cur (q[i]),
      .hi  (from_hi[i]),
      .lo  (from_lo[i]),
      .ld  (pdin[i]),
      .nxt (q_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= RESET_VAL;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 SHALL have parameter RESET_VAL, default 0, value of q after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  clock enable; 0 freezes q, cnt and state.
REQ-006 SHALL have port mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SHALL have port sin_r  input  1  serial in, enters q[WIDTH-1] on shift right.
REQ-008 SHALL have port sin_l  input  1  serial in, enters q[0] on shift left.
REQ-009 SHALL have port pdin  input  WIDTH  parallel load data.
REQ-010 SHALL have port start  input  1  request automatic serialise burst.
REQ-011 SHALL have port q  output  WIDTH  register contents.
REQ-012 SHALL have port sout_r  output  1  q[0], combinational from q.
REQ-013 SHALL have port sout_l  output  1  q[WIDTH-1], combinational from q.
REQ-014 SHALL have port busy  output  1  high while in SHIFT state.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-016 SHALL have port cnt  output  $clog2(WIDTH+1)  bits remaining in burst.

Function
REQ-017 SHALL implement two states: IDLE (manual modes) and SHIFT (burst).
REQ-018 IDLE, en=1, start=0: mode 00 q unchanged; 01 q <= {sin_r, q[WIDTH-1:1]}; 10 q <= {q[WIDTH-2:0], sin_l}; 11 q <= pdin.
REQ-019 IDLE, en=1, start=1: q <= pdin, cnt <= WIDTH, go SHIFT; start has priority over mode.
REQ-020 SHIFT, en=1: q <= {sin_r, q[WIDTH-1:1]}, cnt <= cnt-1; mode and start ignored.
REQ-021 SHIFT, en=1, cnt==1: final shift as REQ-020, cnt <= 0, go IDLE, done=1 next cycle.
REQ-022 done SHALL be registered, high exactly one clk cycle, independent of en.
REQ-023 en=0 in any state: q, cnt, state hold; start not accepted; done still deasserts after one cycle.
REQ-024 start while busy=1 SHALL be ignored, no queueing.
REQ-025 busy SHALL be 1 from the cycle after start is accepted until the cycle cnt reaches 0.
REQ-026 cnt SHALL be 0 in IDLE; never underflows.
REQ-027 Burst SHALL present pdin[0..WIDTH-1] on sout_r, one bit per enabled SHIFT cycle, LSB first.
REQ-028 Zero-latency outputs: sout_r/sout_l follow q same cycle; q updates one edge after inputs sampled.

Reset
REQ-029 rst_n=0 SHALL immediately, without clk, force q=RESET_VAL, cnt=0, busy=0, done=0, state IDLE.
REQ-030 Reset mid-burst SHALL abort; no done pulse generated.
REQ-031 After rst_n rises, first active edge SHALL behave per REQ-018/019.

Verification (WIDTH=4, RESET_VAL=0)
REQ-032 Manual shift right: rst, mode=01, en=1, sin_r=1,0,1,1 over 4 edges -> q=1101, sout_r=1.
REQ-033 Manual shift left and load: mode=11 pdin=1001 -> q=1001; mode=10 sin_l=0 -> q=0010; mode=00 -> q holds 0010.
REQ-034 Burst: pdin=1011, start=1 one cycle, sin_r=0 -> busy=1, cnt 4,3,2,1,0, sout_r 1,1,0,1, done one pulse, final q=0000.
REQ-035 en gap mid-burst: drop en 2 cycles after 2nd shift -> q, cnt frozen at cnt=2; burst completes 2 enabled cycles later, done still single pulse.
REQ-036 Reset mid-burst: rst_n low at cnt=2, asynchronous to clk -> q=0000, busy=0, cnt=0 immediately, no done.
REQ-037 start while busy and mode=11 during burst: pdin ignored, burst completes unaffected with original data.
